// File: rtl/i2c_pkg.sv
// Shared state encoding and bus constants for the I2C temperature-sensor target.
package i2c_pkg;
   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ACK_ADDR,
      WR_DATA,
      ACK_WR,
      RD_DATA,
      RD_ACK
   } i2c_state_t;

   localparam logic       RW_WRITE     = 1'b0;
   localparam logic       RW_READ      = 1'b1;
   localparam logic [6:0] DEFAULT_ADDR = 7'h48;
endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes the scl/sda pins and reports scl edges and START/STOP conditions.
// Outputs are single-cycle pulses derived from the 2nd and 3rd flop of each chain.
module i2c_line_sync (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_scl,
   input  logic i_sda,
   output logic o_scl_rise,
   output logic o_scl_fall,
   output logic o_sda,
   output logic o_start,
   output logic o_stop
);
   logic [2:0] r_scl;
   logic [2:0] r_sda;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_scl <= 3'b111;
         r_sda <= 3'b111;
      end else begin
         r_scl <= {r_scl[1:0], i_scl};
         r_sda <= {r_sda[1:0], i_sda};
      end
   end

   assign o_scl_rise = r_scl[1] & ~r_scl[2];
   assign o_scl_fall = ~r_scl[1] & r_scl[2];
   assign o_sda      = r_sda[1];
   // START/STOP only count while scl has been high for two samples
   assign o_start    = r_scl[1] & r_scl[2] & r_sda[2] & ~r_sda[1];
   assign o_stop     = r_scl[1] & r_scl[2] & ~r_sda[2] & r_sda[1];
endmodule

// File: rtl/i2c_temp_slave.sv
// I2C target: serves a snapshot of temp_in (MSB byte first, alternating) on reads and
// stores every written byte in cfg_reg. Open-drain sda changes only on scl falls.
module i2c_temp_slave
   import i2c_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR = DEFAULT_ADDR,
   parameter logic [7:0] CFG_RESET  = 8'h00
) (
   input  logic        clk,
   input  logic        reset,
   inout  wire         scl,
   inout  wire         sda,
   input  logic [15:0] temp_in,
   output logic [7:0]  cfg_reg,
   output logic        wr_strobe,
   output logic        rd_strobe,
   output logic        busy
);
   i2c_state_t  r_state, w_state_nxt;
   logic [3:0]  r_cnt, w_cnt_nxt;
   logic [7:0]  r_shift, w_shift_nxt;
   logic        r_oe, w_oe_nxt;
   logic        r_rw, w_rw_nxt;
   logic [15:0] r_tx, w_tx_nxt;
   logic        r_byte_sel, w_sel_nxt;
   logic [7:0]  r_cfg, w_cfg_nxt;
   logic        r_wr_stb, w_wr_stb_nxt;
   logic        r_rd_stb, w_rd_stb_nxt;
   logic        r_busy, w_busy_nxt;

   logic        w_scl_rise, w_scl_fall, w_sda, w_start, w_stop;
   logic [7:0]  w_tx_byte, w_tx_next;
   logic [2:0]  w_bit_idx;

   i2c_line_sync u_sync (
      .i_clk      (clk),
      .i_reset    (reset),
      .i_scl      (scl),
      .i_sda      (sda),
      .o_scl_rise (w_scl_rise),
      .o_scl_fall (w_scl_fall),
      .o_sda      (w_sda),
      .o_start    (w_start),
      .o_stop     (w_stop)
   );

   assign w_tx_byte = r_byte_sel ? r_tx[7:0] : r_tx[15:8];
   assign w_tx_next = r_byte_sel ? r_tx[15:8] : r_tx[7:0];
   assign w_bit_idx = 3'd7 - r_cnt[2:0];

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_shift_nxt  = r_shift;
      w_oe_nxt     = r_oe;
      w_rw_nxt     = r_rw;
      w_tx_nxt     = r_tx;
      w_sel_nxt    = r_byte_sel;
      w_cfg_nxt    = r_cfg;
      w_wr_stb_nxt = 1'b0;
      w_rd_stb_nxt = 1'b0;
      w_busy_nxt   = r_busy;
      if (w_start) begin
         w_state_nxt = ADDR;
         w_cnt_nxt   = 4'd0;
         w_oe_nxt    = 1'b0;
      end else if (w_stop) begin
         w_state_nxt = IDLE;
         w_oe_nxt    = 1'b0;
         w_busy_nxt  = 1'b0;
      end else begin
         case (r_state)
            IDLE: w_oe_nxt = 1'b0;
            ADDR: begin
               if (w_scl_rise && r_cnt != 4'd8) begin
                  w_shift_nxt = {r_shift[6:0], w_sda};
                  w_cnt_nxt   = r_cnt + 4'd1;
               end else if (w_scl_fall && r_cnt == 4'd8) begin
                  if (r_shift[7:1] == SLAVE_ADDR) begin
                     w_state_nxt = ACK_ADDR;
                     w_oe_nxt    = 1'b1;
                     w_rw_nxt    = r_shift[0];
                     w_busy_nxt  = 1'b1;
                     w_cnt_nxt   = 4'd0;
                     if (r_shift[0] == RW_READ) begin
                        w_tx_nxt  = temp_in;
                        w_sel_nxt = 1'b0;
                     end
                  end else begin
                     w_state_nxt = IDLE;
                     w_busy_nxt  = 1'b0;
                  end
               end
            end
            ACK_ADDR: begin
               if (w_scl_fall) begin
                  if (r_rw == RW_WRITE) begin
                     w_state_nxt = WR_DATA;
                     w_oe_nxt    = 1'b0;
                     w_cnt_nxt   = 4'd0;
                  end else begin
                     w_state_nxt = RD_DATA;
                     w_oe_nxt    = ~w_tx_byte[7];
                     w_cnt_nxt   = 4'd1;
                  end
               end
            end
            WR_DATA: begin
               if (w_scl_rise && r_cnt != 4'd8) begin
                  w_shift_nxt = {r_shift[6:0], w_sda};
                  w_cnt_nxt   = r_cnt + 4'd1;
               end else if (w_scl_fall && r_cnt == 4'd8) begin
                  w_cfg_nxt    = r_shift;
                  w_wr_stb_nxt = 1'b1;
                  w_oe_nxt     = 1'b1;
                  w_state_nxt  = ACK_WR;
               end
            end
            ACK_WR: begin
               if (w_scl_fall) begin
                  w_state_nxt = WR_DATA;
                  w_oe_nxt    = 1'b0;
                  w_cnt_nxt   = 4'd0;
               end
            end
            RD_DATA: begin
               // r_cnt holds how many bits of the current byte are already on the bus
               if (w_scl_fall) begin
                  if (r_cnt == 4'd8) begin
                     w_state_nxt = RD_ACK;
                     w_oe_nxt    = 1'b0;
                     w_cnt_nxt   = 4'd0;
                  end else begin
                     w_oe_nxt  = ~w_tx_byte[w_bit_idx];
                     w_cnt_nxt = r_cnt + 4'd1;
                  end
               end
            end
            RD_ACK: begin
               if (w_scl_rise && r_cnt == 4'd0) begin
                  w_rd_stb_nxt = 1'b1;
                  if (w_sda) begin
                     w_state_nxt = IDLE;
                     w_busy_nxt  = 1'b0;
                  end else begin
                     w_cnt_nxt = 4'd1;
                  end
               end else if (w_scl_fall && r_cnt == 4'd1) begin
                  w_state_nxt = RD_DATA;
                  w_sel_nxt   = ~r_byte_sel;
                  w_oe_nxt    = ~w_tx_next[7];
                  w_cnt_nxt   = 4'd1;
               end
            end
            default: begin
               w_state_nxt = IDLE;
               w_oe_nxt    = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_cnt      <= 4'd0;
         r_shift    <= 8'd0;
         r_oe       <= 1'b0;
         r_rw       <= RW_WRITE;
         r_tx       <= 16'd0;
         r_byte_sel <= 1'b0;
         r_cfg      <= CFG_RESET;
         r_wr_stb   <= 1'b0;
         r_rd_stb   <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_shift    <= w_shift_nxt;
         r_oe       <= w_oe_nxt;
         r_rw       <= w_rw_nxt;
         r_tx       <= w_tx_nxt;
         r_byte_sel <= w_sel_nxt;
         r_cfg      <= w_cfg_nxt;
         r_wr_stb   <= w_wr_stb_nxt;
         r_rd_stb   <= w_rd_stb_nxt;
         r_busy     <= w_busy_nxt;
      end
   end

   assign sda       = r_oe ? 1'b0 : 1'bz;
   assign cfg_reg   = r_cfg;
   assign wr_strobe = r_wr_stb;
   assign rd_strobe = r_rd_stb;
   assign busy      = r_busy;
endmodule

// File: doc/i2c_temp_slave.md
Name: i2c_temp_slave

Overview:
- I2C target (slave) that emulates the temperature sensor the team's I2C master polls.
- It shares the open-drain `scl`/`sda` bus with that master. The bench pulls both lines up.
- Behaviour: answers a read at its 7-bit address with a 16-bit temperature word, MSB first. Accepts write bytes into an 8-bit config register.
- Gives the master's LCD/temperature path a synthesizable bus partner for simulation and on-board loopback.

Parameters:
- SLAVE_ADDR, 7'h48, 7-bit bus address matched against the first byte after START.
- CFG_RESET, 8'h00, reset value of the config register.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- scl  inout  1  I2C clock. Never driven (no clock stretching); input only, always 'z'.
- sda  inout  1  I2C data. Open-drain: driven 0 when the internal oe is high, else 'z'.
- temp_in  input  16  live temperature value to serve on reads.
- cfg_reg  output  8  last byte written by the master.
- wr_strobe  output  1  one-cycle pulse when a written byte is committed to cfg_reg.
- rd_strobe  output  1  one-cycle pulse when the master ACKs or NACKs a transmitted byte.
- busy  output  1  high from an address-matched START until STOP or NACK-terminated read.

Behaviour:
- Reset (synchronous, 1 cycle):
  - state=IDLE, sda oe=0 (bus released).
  - cfg_reg=CFG_RESET; wr_strobe=0, rd_strobe=0, busy=0.
  - bit counter=0; synchronizers loaded with 1.
- Input conditioning:
  - scl and sda each pass a 2-FF synchronizer plus a third delay FF for edge detect.
  - scl_rise/scl_fall are single-cycle pulses.
  - Pin-to-action latency is 3 clk. The master's SCL low/high phases must each be at least 8 clk.
- START: synchronized sda falls while synchronized scl is high. Recognized in any state, including repeated START.
  - Go to ADDR, bit counter=0, release sda.
- STOP: sda rises while scl is high. Recognized in any state.
  - Go to IDLE, release sda, busy=0. cfg_reg is unchanged.
- Sampling and driving:
  - Data is sampled on scl_rise.
  - The slave changes its sda drive only on scl_fall, so its own drive can never create a false START/STOP.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB first on scl_rise. After bit 8:
    - If addr[7:1]==SLAVE_ADDR: on the next scl_fall assert oe (ACK) and go to ACK_ADDR. Latch rw=bit0. busy=1. If rw=1, snapshot temp_in into a 16-bit tx register at this moment.
    - Otherwise go to IDLE, keep sda released (NACK), and ignore the bus until the next START.
  - ACK_ADDR: on scl_fall release oe.
    - rw=0 → WR_DATA.
    - rw=1 → RD_DATA. Drive bit 7 of the current tx byte on that same scl_fall (oe=~bit).
  - WR_DATA: shift 8 bits on scl_rise. After bit 8, on the next scl_fall:
    - cfg_reg <= shifted byte; wr_strobe pulses 1 cycle; oe=1 → ACK_WR.
    - Every byte overwrites cfg_reg.
  - ACK_WR: on scl_fall release oe → WR_DATA, counter=0.
  - RD_DATA:
    - On each scl_fall drive the next bit. The first byte is tx[15:8], the second is tx[7:0].
    - Byte select toggles per byte: a third byte repeats the MSB, and so on. The snapshot is not refreshed within one transaction.
    - After 8 bits, on the next scl_fall release oe → RD_ACK.
  - RD_ACK: sample sda on scl_rise; rd_strobe pulses 1 cycle.
    - ACK (0): on the next scl_fall → RD_DATA with the next byte.
    - NACK (1): go to IDLE, busy=0, sda stays released.
- Simultaneous events:
  - START/STOP detection has priority over scl edge processing in the same cycle.
  - reset has priority over everything.
- Reset mid-operation: sda is released on the clock edge where reset is sampled; cfg_reg returns to CFG_RESET.

Decomposition:
- Shared package i2c_pkg holds:
  - the state enum/localparams (IDLE, ADDR, ACK_ADDR, WR_DATA, ACK_WR, RD_DATA, RD_ACK);
  - RW_WRITE=0 and RW_READ=1;
  - default address 7'h48.
- One natural sub-module: i2c_line_sync. It is the 2-FF synchronizer plus edge/START/STOP detector, instanced once for the scl/sda pair.

Test Plan:
- Write: START, byte 0x90, ACK, data 0x5A, STOP → slave ACKs both bytes (sda=0 on 9th clock). cfg_reg=0x5A, wr_strobe exactly 1 pulse, busy=0 after STOP.
- Address miss: START, byte 0x94 (addr 0x4A) → sda stays 1 on 9th clock, busy stays 0, cfg_reg unchanged; a following 0x90 transaction still works.
- Read: temp_in=16'h1980, START, byte 0x91, master ACKs byte 1 and NACKs byte 2 → bytes read are 0x19 then 0x80, rd_strobe 2 pulses, sda released after NACK.
- Snapshot and wrap:
  - temp_in changes to 16'h0000 mid-read → bytes still 0x19/0x80.
  - A third ACKed byte returns 0x19.
- Repeated START: write 0x90, 0x01, then Sr + 0x91 read → cfg_reg=0x01, read returns the current temp_in MSB/LSB.
- Reset mid-read: assert reset while the slave drives sda=0 → sda 'z' at the next posedge. State IDLE, cfg_reg=CFG_RESET, and no response until a new START.
